i2s_tx_multi: RTL and testbench
===============================

Name: i2s_tx_multi

Overview:
- Parametrised successor to the fixed 16-bit stereo I2S serialiser used at the DECA top level.
- Generates MCK, SCK and LR from the system clock, and serialises left/right samples of configurable width into a configurable slot size.
- Supports I2S and left-justified framing, soft mute, a valid/ready sample handshake with a one-pair holding buffer, and underrun reporting.
- Sits between the machine's audio mixer and the TLV320AIC3254 DAC pins.

Parameters:
- DW, 16: sample width in bits, two's complement, MSB first.
- SLOT, 32: SCK periods per channel slot. Must be ≥ DW. Frame length = 2*SLOT bits.
- SCKDIV, 16: system clocks per SCK period. Even, ≥ 4.
- MCKDIV, 4: system clocks per MCK period. Even, ≥ 2.

Ports:
- clock, input, 1: system clock (56 MHz on DECA).
- reset, input, 1: asynchronous active-low reset.
- mode, input, 1: 0 = I2S (data delayed one SCK after the LR edge); 1 = left-justified. Sampled at frame start only.
- mute, input, 1: 1 = serialise zeros. Sampled at frame start only.
- ldata, input, DW: left sample.
- rdata, input, DW: right sample.
- valid, input, 1: ldata/rdata hold a new sample pair.
- ready, output, 1: holding buffer empty; pair accepted when valid & ready.
- mck, output, 1: master clock, 50% duty, clock/MCKDIV.
- sck, output, 1: bit clock, 50% duty, clock/SCKDIV.
- lr, output, 1: word select; 0 = left slot, 1 = right slot.
- d, output, 1: serial data, changes on SCK falling edge.
- underrun, output, 1: one-clock pulse when a frame starts with the holding buffer empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - mck=0, sck=0, lr=0, d=0, ready=1, underrun=0.
  - All counters, holding and shift registers are cleared to 0; the "last pair" register is cleared to 0.
  - Deassertion restarts at frame bit 0, left slot.
- MCK: counter 0..MCKDIV-1. mck=1 for counts ≥ MCKDIV/2. Free-running and independent of SCK.
- SCK divider: counter c in 0..SCKDIV-1.
  - sck rises when c goes to SCKDIV/2; sck falls on wrap to 0.
  - The "fall" strobe is the cycle c wraps; all lr/d updates occur on that strobe only.
- Bit counter b in 0..2*SLOT-1 advances on each fall strobe and wraps to 0. Channel ch = b ≥ SLOT; slot position p = b mod SLOT. lr = ch in both modes.
- Frame start is the fall strobe where b wraps to 0 (and the first strobe after reset). On frame start:
  - If the holding buffer is full: copy the pair to the shift/last registers and set ready=1 in the same cycle.
  - Otherwise: reload the last pair and pulse underrun for exactly one clock.
  - Latch mode and mute. If mute=1, load zeros; the holding buffer is still consumed.
- Handshake: when valid & ready at a clock edge, capture ldata/rdata and set ready=0 on the next cycle.
  - If valid & ready coincides with a frame start that empties the buffer, the frame uses the previously held pair; the new pair fills the buffer and ready=0.
  - If a frame start occurs with the buffer empty and valid=1 in that same cycle, the new pair is captured but not used until the next frame, and underrun still pulses.
- Bit mapping, left-justified (mode=1): d = sample_ch[DW-1-p] for p < DW, else 0.
- Bit mapping, I2S (mode=0): d at position p carries the left-justified bit for position p-1 of the same channel. At p=0 it carries the left-justified bit at position SLOT-1 of the previous channel, where the previous channel of the left slot is the prior frame's right slot. That bit is 0 whenever SLOT > DW.
- Word select transitions: lr and d change together on the same fall strobe. The LR edge is coincident with the first bit in left-justified mode and one SCK ahead of the MSB in I2S mode.
- Zero padding: bits below the LSB are 0; no sign extension.
- Changing mode or mute mid-frame has no effect until the next frame start.

Test Plan:
- Reset values: hold reset=0 for 10 clocks. Check mck=sck=lr=d=0, ready=1, underrun=0. Release and check sck period = 16 clocks and mck period = 4 clocks.
- Left-justified framing (DW=16, SLOT=16, mode=1): send ldata=16'hA5F0, rdata=16'h0F5A before the first frame. Sampling d on sck rising edges must give A5F0 MSB-first with lr=0, then 0F5A with lr=1.
- I2S framing (same data, mode=0, SLOT=32): first bit after lr falls is 0, then A5F0 MSB-first, then 15 zeros. The right slot likewise carries 0F5A starting at b=33.
- Underrun: supply one pair and then nothing. The next frame repeats the same pair and underrun pulses exactly once per starved frame. A new pair stops the pulses.
- Back-pressure: hold valid=1 with changing data. ready deasserts after capture and reasserts only at the frame start. Exactly one pair is consumed per 2*SLOT*SCKDIV clocks and no pair is skipped.
- Mute and mid-frame reset: with mute=1, d stays 0 for the whole frame while ready still cycles. Asserting reset at b=20 immediately forces all outputs to their reset values; after release, the frame restarts at b=0 with lr=0.

Source files
------------

// File: rtl/i2s_tx_multi.sv
// i2s_tx_multi: parametrised I2S / left-justified stereo serialiser.
// Generates MCK, SCK and LR from the system clock and shifts out one sample pair
// per frame. A single-entry holding buffer decouples the valid/ready producer
// from the frame rate; a starved frame repeats the last pair and pulses underrun.
module i2s_tx_multi #(
  parameter int unsigned DW     = 16,
  parameter int unsigned SLOT   = 32,
  parameter int unsigned SCKDIV = 16,
  parameter int unsigned MCKDIV = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          mode,
  input  logic          mute,
  input  logic [DW-1:0] ldata,
  input  logic [DW-1:0] rdata,
  input  logic          valid,
  output logic          ready,
  output logic          mck,
  output logic          sck,
  output logic          lr,
  output logic          d,
  output logic          underrun
);

  localparam int unsigned CW = (SCKDIV > 2) ? $clog2(SCKDIV) : 1;
  localparam int unsigned MW = (MCKDIV > 2) ? $clog2(MCKDIV) : 1;
  localparam int unsigned BW = $clog2(2 * SLOT);
  localparam int unsigned IW = (DW > 2) ? $clog2(DW) : 1;

  localparam logic [CW-1:0] CMAX  = CW'(SCKDIV - 1);
  localparam logic [CW-1:0] CHALF = CW'(SCKDIV / 2);
  localparam logic [MW-1:0] MMAX  = MW'(MCKDIV - 1);
  localparam logic [MW-1:0] MHALF = MW'(MCKDIV / 2);
  localparam logic [BW-1:0] BMAX  = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0] BSLOT = BW'(SLOT);

  logic [MW-1:0] mc_q, mc_d;
  logic [CW-1:0] c_q, c_d;
  logic [BW-1:0] b_q, b_d;
  logic          first_q;
  logic [DW-1:0] hold_l_q, hold_r_q;
  logic [DW-1:0] last_l_q, last_r_q;
  logic [DW-1:0] cur_l_q, cur_r_q;
  logic          mode_q;

  logic          strobe, fstart, ch, new_mode, d_d;
  logic [DW-1:0] src_l, src_r, new_l, new_r, sel;
  int unsigned   pos;

  // Left-justified bit of a sample at slot position pos; zero below the LSB.
  function automatic logic lj_bit(input logic [DW-1:0] s, input int unsigned p);
    logic r;
    r = 1'b0;
    if (p < DW) r = s[IW'(DW - 1 - p)];
    return r;
  endfunction

  // Divider next states, frame bookkeeping and the bit to drive after the strobe.
  always_comb begin
    mc_d   = (mc_q == MMAX) ? '0 : mc_q + MW'(1);
    c_d    = (c_q == CMAX) ? '0 : c_q + CW'(1);
    strobe = (c_q == CMAX);
    // First strobe after reset holds b at 0 so the frame opens on bit 0.
    fstart = strobe && (first_q || (b_q == BMAX));
    b_d    = (first_q || (b_q == BMAX)) ? '0 : b_q + BW'(1);

    // ready=1 means the holding buffer is empty: fall back to the last pair.
    src_l    = ready ? last_l_q : hold_l_q;
    src_r    = ready ? last_r_q : hold_r_q;
    new_l    = cur_l_q;
    new_r    = cur_r_q;
    new_mode = mode_q;
    if (fstart) begin
      new_l    = mute ? '0 : src_l;
      new_r    = mute ? '0 : src_r;
      new_mode = mode;
    end

    ch  = (b_d >= BSLOT);
    pos = ch ? 32'(b_d - BSLOT) : 32'(b_d);
    sel = ch ? new_r : new_l;

    // I2S lags left-justified by one bit; slot bit 0 borrows the previous
    // channel's last bit (the old frame's right slot for the left channel).
    if (new_mode)       d_d = lj_bit(sel, pos);
    else if (pos != 0)  d_d = lj_bit(sel, pos - 1);
    else if (ch)        d_d = lj_bit(new_l, SLOT - 1);
    else                d_d = lj_bit(cur_r_q, SLOT - 1);
  end

  // Free-running MCK and SCK dividers with registered clock outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mc_q <= '0;
      c_q  <= '0;
      mck  <= 1'b0;
      sck  <= 1'b0;
    end else begin
      mc_q <= mc_d;
      c_q  <= c_d;
      mck  <= (mc_d >= MHALF);
      sck  <= (c_d >= CHALF);
    end
  end

  // Frame position, per-frame sample registers and LR/D outputs, all on the fall strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_q      <= '0;
      first_q  <= 1'b1;
      cur_l_q  <= '0;
      cur_r_q  <= '0;
      mode_q   <= 1'b0;
      lr       <= 1'b0;
      d        <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= fstart && ready;
      if (strobe) begin
        b_q     <= b_d;
        first_q <= 1'b0;
        cur_l_q <= new_l;
        cur_r_q <= new_r;
        mode_q  <= new_mode;
        lr      <= ch;
        d       <= d_d;
      end
    end
  end

  // Holding buffer handshake and last-pair memory for underrun repeats.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready    <= 1'b1;
      hold_l_q <= '0;
      hold_r_q <= '0;
      last_l_q <= '0;
      last_r_q <= '0;
    end else begin
      if (fstart && !ready) begin
        last_l_q <= hold_l_q;
        last_r_q <= hold_r_q;
      end
      // valid&ready implies empty, so capture and consume never coincide.
      if (valid && ready) begin
        hold_l_q <= ldata;
        hold_r_q <= rdata;
        ready    <= 1'b0;
      end else if (fstart) begin
        ready    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_multi.sv
// Bench for i2s_tx_multi: two instances (SLOT=32 and SLOT=16) share clock,
// reset, mode and mute, each with its own producer. A frame-level model
// predicts every output on every cycle; literal checks pin the model.
module tb_i2s_tx_multi;

  localparam int DW     = 16;
  localparam int SCKDIV = 16;
  localparam int MCKDIV = 4;
  localparam int SLOT_A = 32;
  localparam int SLOT_B = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic mode  = 1'b0;
  logic mute  = 1'b0;
  logic [1:0]       v;
  logic [1:0][15:0] ld;
  logic [1:0][15:0] rd;
  logic [1:0] rdy, mck_o, sck_o, lr_o, d_o, und_o;

  int total = 0;
  int bad   = 0;
  int und_cnt [2];
  int seq [2];

  always #5 clock = ~clock;

  i2s_tx_multi #(.DW(DW), .SLOT(SLOT_A), .SCKDIV(SCKDIV), .MCKDIV(MCKDIV)) u_a (
    .clock(clock), .reset(reset), .mode(mode), .mute(mute),
    .ldata(ld[0]), .rdata(rd[0]), .valid(v[0]), .ready(rdy[0]),
    .mck(mck_o[0]), .sck(sck_o[0]), .lr(lr_o[0]), .d(d_o[0]), .underrun(und_o[0])
  );

  i2s_tx_multi #(.DW(DW), .SLOT(SLOT_B), .SCKDIV(SCKDIV), .MCKDIV(MCKDIV)) u_b (
    .clock(clock), .reset(reset), .mode(mode), .mute(mute),
    .ldata(ld[1]), .rdata(rd[1]), .valid(v[1]), .ready(rdy[1]),
    .mck(mck_o[1]), .sck(sck_o[1]), .lr(lr_o[1]), .d(d_o[1]), .underrun(und_o[1])
  );

  // ---------------- frame-level model ----------------
  int         mk     [2];
  bit         mfull  [2];
  bit         mmode  [2];
  bit         mund   [2];
  logic [15:0] mhl [2], mhr [2], mlastl [2], mlastr [2], mcurl [2], mcurr [2], mprevr [2];

  function automatic int slot_of(input int i);
    return (i == 0) ? SLOT_A : SLOT_B;
  endfunction

  function automatic logic lj(input logic [15:0] s, input int q);
    if (q < DW) return s[DW-1-q];
    return 1'b0;
  endfunction

  task automatic model_step(input int i);
    int sl, n;
    bit full_pre, acc;
    logic [15:0] pl, pr;
    sl = slot_of(i);
    if (!reset) begin
      mk[i] = 0; mfull[i] = 0; mmode[i] = 0; mund[i] = 0;
      mhl[i] = '0; mhr[i] = '0; mlastl[i] = '0; mlastr[i] = '0;
      mcurl[i] = '0; mcurr[i] = '0; mprevr[i] = '0;
      return;
    end
    mk[i]++;
    full_pre = mfull[i];
    acc      = v[i] && !full_pre;
    mund[i]  = 0;
    if (mk[i] % SCKDIV == 0) begin
      n = mk[i] / SCKDIV;
      if ((n - 1) % (2 * sl) == 0) begin
        mprevr[i] = mcurr[i];
        if (full_pre) begin
          pl = mhl[i]; pr = mhr[i];
          mlastl[i] = pl; mlastr[i] = pr;
          mfull[i] = 0;
        end else begin
          pl = mlastl[i]; pr = mlastr[i];
          mund[i] = 1;
        end
        mmode[i] = mode;
        mcurl[i] = mute ? 16'h0 : pl;
        mcurr[i] = mute ? 16'h0 : pr;
      end
    end
    if (acc) begin
      mfull[i] = 1;
      mhl[i] = ld[i];
      mhr[i] = rd[i];
    end
  endtask

  function automatic logic exp_lr(input int i);
    int n, sl;
    sl = slot_of(i);
    n  = mk[i] / SCKDIV;
    if (n == 0) return 1'b0;
    return (((n - 1) % (2 * sl)) >= sl);
  endfunction

  function automatic logic exp_d(input int i);
    int n, sl, b, p;
    bit ch;
    logic [15:0] s;
    sl = slot_of(i);
    n  = mk[i] / SCKDIV;
    if (n == 0) return 1'b0;
    b  = (n - 1) % (2 * sl);
    ch = (b >= sl);
    p  = b % sl;
    s  = ch ? mcurr[i] : mcurl[i];
    if (mmode[i]) return lj(s, p);
    if (p > 0)    return lj(s, p - 1);
    if (ch)       return lj(mcurl[i], sl - 1);
    return lj(mprevr[i], sl - 1);
  endfunction

  initial forever begin
    @(posedge clock);
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int i, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%b want=%b at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%h want=%h at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_mck"}, i, mck_o[i], 1'b0);
      chk({nm, "_sck"}, i, sck_o[i], 1'b0);
      chk({nm, "_lr"},  i, lr_o[i],  1'b0);
      chk({nm, "_d"},   i, d_o[i],   1'b0);
      chk({nm, "_rdy"}, i, rdy[i],   1'b1);
      chk({nm, "_und"}, i, und_o[i], 1'b0);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        chk("cyc_rst_mck", i, mck_o[i], 1'b0);
        chk("cyc_rst_sck", i, sck_o[i], 1'b0);
        chk("cyc_rst_lr",  i, lr_o[i],  1'b0);
        chk("cyc_rst_d",   i, d_o[i],   1'b0);
        chk("cyc_rst_rdy", i, rdy[i],   1'b1);
        chk("cyc_rst_und", i, und_o[i], 1'b0);
      end else begin
        chk("cyc_mck", i, mck_o[i], ((mk[i] % MCKDIV) >= MCKDIV / 2));
        chk("cyc_sck", i, sck_o[i], ((mk[i] % SCKDIV) >= SCKDIV / 2));
        chk("cyc_lr",  i, lr_o[i],  exp_lr(i));
        chk("cyc_d",   i, d_o[i],   exp_d(i));
        chk("cyc_rdy", i, rdy[i],   !mfull[i]);
        chk("cyc_und", i, und_o[i], mund[i]);
      end
      if (und_o[i]) und_cnt[i]++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int i);
    logic [15:0] s;
    s = 16'(seq[i]);
    ld[i] = 16'h8001 ^ (s * 16'h1357);
    rd[i] = 16'h4003 ^ (s * 16'h2469);
  endtask

  // Producer: keep valid high and advance to the next pair after each handshake.
  task automatic run_src(input int n, output int ones0, output int ones1);
    logic [1:0] acc;
    ones0 = 0;
    ones1 = 0;
    repeat (n) begin
      acc = v & rdy & {2{reset}};
      @(posedge clock); #1;
      for (int i = 0; i < 2; i++) if (acc[i]) begin seq[i]++; drive(i); end
      ones0 += int'(d_o[0]);
      ones1 += int'(d_o[1]);
    end
  endtask

  // Sample d at 64 consecutive SCK rising edges, starting just after a strobe.
  task automatic collect(output logic [63:0] ba, output logic [63:0] bb, input int flip_at);
    ba = '0;
    bb = '0;
    for (int n = 0; n < 64; n++) begin
      repeat (8) @(posedge clock);
      #1;
      ba = {ba[62:0], d_o[0]};
      bb = {bb[62:0], d_o[1]};
      if (n == flip_at) mode = 1'b0;
      repeat (8) @(posedge clock);
    end
  endtask

  initial begin
    logic [63:0] ba, bb;
    int o0, o1;
    v = '0; ld = '0; rd = '0;
    mode = 1'b1; mute = 1'b0; reset = 1'b0;
    seq[0] = 0; seq[1] = 0;
    und_cnt[0] = 0; und_cnt[1] = 0;

    repeat (10) @(posedge clock);
    #1;
    chk_reset_vals("lit_rst");

    ld[0] = 16'hA5F0; rd[0] = 16'h0F5A;
    ld[1] = 16'hA5F0; rd[1] = 16'h0F5A;
    v = 2'b11;
    reset = 1'b1;
    @(posedge clock); #1;
    v = 2'b00;
    for (int i = 0; i < 2; i++) chk("lit_rdy_after_cap", i, rdy[i], 1'b0);

    repeat (15) @(posedge clock); #1;
    for (int i = 0; i < 2; i++) begin
      chk("lit_lj_msb", i, d_o[i], 1'b1);
      chk("lit_lj_lr0", i, lr_o[i], 1'b0);
      chk("lit_frame_rdy", i, rdy[i], 1'b1);
    end

    // Left-justified frames; switch to I2S mid-frame for the next frame start.
    collect(ba, bb, 40);
    #1;
    chk32("lit_lj_left",  0, ba[63:32], 32'hA5F0_0000);
    chk32("lit_lj_right", 0, ba[31:0],  32'h0F5A_0000);
    chk32("lit_lj_l0", 1, {16'h0, bb[63:48]}, 32'h0000_A5F0);
    chk32("lit_lj_r0", 1, {16'h0, bb[47:32]}, 32'h0000_0F5A);
    chk32("lit_lj_l1", 1, {16'h0, bb[31:16]}, 32'h0000_A5F0);
    chk32("lit_lj_r1", 1, {16'h0, bb[15:0]},  32'h0000_0F5A);
    chk32("lit_und_cnt1", 0, 32'(und_cnt[0]), 32'd0);
    chk32("lit_und_cnt1", 1, 32'(und_cnt[1]), 32'd1);

    // I2S frames, starved: the last pair repeats, delayed by one bit.
    collect(ba, bb, -1);
    #1;
    chk32("lit_i2s_left",  0, ba[63:32], 32'h52F8_0000);
    chk32("lit_i2s_right", 0, ba[31:0],  32'h07AD_0000);
    chk32("lit_i2s_l0", 1, {16'h0, bb[63:48]}, 32'h0000_52F8);
    chk32("lit_i2s_r0", 1, {16'h0, bb[47:32]}, 32'h0000_07AD);
    chk32("lit_i2s_l1", 1, {16'h0, bb[31:16]}, 32'h0000_52F8);
    chk32("lit_i2s_r1", 1, {16'h0, bb[15:0]},  32'h0000_07AD);
    chk32("lit_und_cnt2", 0, 32'(und_cnt[0]), 32'd1);
    chk32("lit_und_cnt2", 1, 32'(und_cnt[1]), 32'd3);

    // Back-pressure: valid held high, one pair consumed per frame.
    drive(0);
    drive(1);
    v = 2'b11;
    run_src(3072, o0, o1);
    chk32("lit_bp_pairs", 0, 32'(seq[0]), 32'd3);
    chk32("lit_bp_pairs", 1, 32'(seq[1]), 32'd6);
    chk32("lit_bp_und", 0, 32'(und_cnt[0]), 32'd2);
    chk32("lit_bp_und", 1, 32'(und_cnt[1]), 32'd4);

    // Mute raised mid-frame: takes effect at the next frame start only.
    mute = 1'b1;
    run_src(1024, o0, o1);
    run_src(1024, o0, o1);
    chk32("lit_mute_ones", 0, 32'(o0), 32'd0);
    chk32("lit_mute_ones", 1, 32'(o1), 32'd0);
    chk32("lit_mute_pairs", 0, 32'(seq[0]), 32'd5);
    chk32("lit_mute_pairs", 1, 32'(seq[1]), 32'd10);
    mute = 1'b0;
    run_src(1024, o0, o1);

    // Reset asserted at bit 20 of a frame of the SLOT=32 instance.
    run_src(20 * SCKDIV + 3, o0, o1);
    reset = 1'b0;
    #1;
    chk_reset_vals("lit_midrst");
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    run_src(16, o0, o1);
    for (int i = 0; i < 2; i++) begin
      chk("lit_restart_lr", i, lr_o[i], 1'b0);
      chk("lit_restart_d",  i, d_o[i],  1'b0);
    end
    run_src(32 * SCKDIV, o0, o1);
    chk("lit_restart_lr32", 0, lr_o[0], 1'b1);
    chk("lit_restart_lr32", 1, lr_o[1], 1'b0);
    run_src(600, o0, o1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
